// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame geometry.
// The transmitter on the same board uses the same state encoding.
package uart_pkg;

    localparam int OVS_DEFAULT    = 16;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

endpackage

// File: rtl/uart_receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line.
// Both flops reset high so an idle line never looks like a start bit.
module rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with oversampled start-bit centring and one-clock strobes.
// Optional good-frame counter enabled by RX_FRAME_CNT_EN.
//
//  state | meaning
//  IDLE  | line idle, waiting for synced rx low on a tick
//  START | counting to start-bit centre, rejecting glitches
//  DATA  | sampling DATA_W bits at their centres, LSB first
//  STOP  | sampling the stop bit, issuing rx_valid or frame_err
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVS    = OVS_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_tick,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              rx_busy,
    output logic [1:0]        state_out,
    output logic [15:0]       frame_cnt
);

    localparam int TICK_W = $clog2(OVS);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    logic rx_s;

    rx_sync u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    uart_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Strobes default low every clock so they stay one clock wide however far apart ticks are.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (rx_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_W-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef RX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else if (valid_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = err_q;
    assign rx_busy   = (state_q != IDLE);
    assign state_out = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven at the line level and
// the expected strobe/byte is queued; a monitor pops on every strobe.
module tb_uart_receiver;

    localparam int OVS     = 16;
    localparam int TICK_P  = 4;
    localparam int BIT_CLK = OVS * TICK_P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_tick = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  data_out;
    logic        rx_valid;
    logic        frame_err;
    logic        rx_busy;
    logic [1:0]  state_out;
    logic [15:0] frame_cnt;

    uart_receiver #(.OVS(OVS), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_tick   (rx_tick),
        .rx        (rx),
        .data_out  (data_out),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy),
        .state_out (state_out),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int tick_div = 0;
    always @(posedge clk) begin
        tick_div <= (tick_div == TICK_P - 1) ? 0 : tick_div + 1;
        rx_tick  <= (tick_div == TICK_P - 1);
    end

    typedef struct {
        bit       is_err;
        bit [7:0] data;
    } exp_t;

    exp_t      exp_q[$];
    bit [7:0]  last_good = 8'h00;
    bit [15:0] fc_exp = 16'd0;
    int        n_checks = 0;
    int        n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [15:0] fc_model();
`ifdef RX_FRAME_CNT_EN
        return fc_exp;
`else
        return 16'd0;
`endif
    endfunction

    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            fc_exp      = 16'd0;
            prev_strobe = 1'b0;
        end else begin
            if (rx_valid || frame_err) begin
                chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, rx_valid, frame_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_err) fc_exp = fc_exp + 16'd1;
                    chk("strobe_kind", {30'd0, rx_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
                    chk("data_out", {24'd0, data_out}, {24'd0, e.data});
                    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, fc_model()});
                end
            end
            prev_strobe = rx_valid || frame_err;
        end
    end

    task automatic expect_frame(input bit [7:0] d, input bit stop_ok);
        exp_t e;
        if (stop_ok) last_good = d;
        e.is_err = !stop_ok;
        e.data   = last_good;
        exp_q.push_back(e);
    endtask

    task automatic drive_bits(input bit [7:0] d, input bit stop_ok);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BIT_CLK) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input bit [7:0] d, input bit stop_ok);
        expect_frame(d, stop_ok);
        drive_bits(d, stop_ok);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, (n >= 3000)}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_state", {30'd0, state_out}, 32'd0);
        chk("rst_strobes", {30'd0, rx_valid, frame_err}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // good frame, with a mid-frame busy/state probe
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (3 * BIT_CLK) @(negedge clk);
                chk("busy_mid", {31'd0, rx_busy}, 32'd1);
                chk("state_mid", {30'd0, state_out}, 32'd2);
            end
        join
        drain();
        chk("busy_after", {31'd0, rx_busy}, 32'd0);

        // short low glitch must be rejected at the start-bit centre
        rx = 1'b0;
        repeat (4 * TICK_P) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("glitch_state", {30'd0, state_out}, 32'd0);
        chk("glitch_data", {24'd0, data_out}, 32'hA5);

        send_frame(8'h3C, 1'b0);
        drain();
        chk("err_keeps_data", {24'd0, data_out}, 32'hA5);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain();

        // break: two framing errors, then the third start is rejected on release
        expect_frame(8'h00, 1'b0);
        expect_frame(8'h00, 1'b0);
        rx = 1'b0;
        repeat (310 * TICK_P) @(negedge clk);
        rx = 1'b1;
        drain();
        chk("break_data", {24'd0, data_out}, 32'hFF);

        // reset in the middle of data bit 4
        fork
            drive_bits(8'hC3, 1'b1);
            begin
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                chk("mid_rst_state", {30'd0, state_out}, 32'd0);
                chk("mid_rst_data", {24'd0, data_out}, 32'd0);
                chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
                chk("mid_rst_cnt", {16'd0, frame_cnt}, 32'd0);
            end
        join
        rx = 1'b1;
        last_good = 8'h00;
        rst_n = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("post_rst_queue", exp_q.size(), 32'd0);
        send_frame(8'h5A, 1'b1);
        drain();

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b1);
        drain();
        chk("frame_cnt_3", {16'd0, frame_cnt}, {16'd0, fc_model()});

`ifdef RX_FRAME_CNT_EN
        force dut.frame_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_q;
        fc_exp = 16'hFFFE;
        send_frame(8'h81, 1'b1);
        send_frame(8'h7E, 1'b1);
        drain();
        chk("frame_cnt_wrap", {16'd0, frame_cnt}, 32'd0);
`endif

        for (int k = 0; k < 16; k++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 100)) @(negedge clk);
        end
        drain();
        chk("final_data", {24'd0, data_out}, {24'd0, last_good});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
